// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV64M multiply/divide unit: one op per handshake, result with its tag after N+2 cycles.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and multiply-by-zero finish in one cycle.
module muldiv_unit #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             word,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [TAG_W-1:0] tag,
    input  logic             flush,
    output logic             out_valid,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e              state_q;
    logic [2:0]          op_q;
    logic                word_q;
    logic                neg1_q;
    logic                neg2_q;
    logic                div0_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     d_q;     // multiplicand / divisor magnitude
    logic [XLEN-1:0]     s_q;     // multiplier / dividend, MSB-aligned and shifted left
    logic [2*XLEN-1:0]   acc_q;   // product, or {remainder, quotient}
    logic [TAG_W-1:0]    tag_q;
    logic [XLEN-1:0]     result_q;
    logic [TAG_W-1:0]    out_tag_q;
    logic                out_valid_q;

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = (sgn && v[31]) ? '1 : '0;
        r[31:0] = v;
        return r;
    endfunction

    // Input decode for the accept edge
    logic            word_eff;
    logic            is_div;
    logic            op1_signed;
    logic            op2_signed;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    logic            neg1;
    logic            neg2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [CW-1:0]   n_eff;
    int unsigned     shamt;
    logic            div0;

    always_comb begin
        word_eff   = (XLEN == 64) && word;
        is_div     = op[2];
        op1_signed = op[2] ? !op[0] : (op != 3'd3);
        op2_signed = op[2] ? !op[0] : (op[1:0] == 2'd0 || op[1:0] == 2'd1);
        e1         = word_eff ? ext32(op1[31:0], op1_signed) : op1;
        e2         = word_eff ? ext32(op2[31:0], op2_signed) : op2;
        neg1       = op1_signed && e1[XLEN-1];
        neg2       = op2_signed && e2[XLEN-1];
        mag1       = neg1 ? -e1 : e1;
        mag2       = neg2 ? -e2 : e2;
        n_eff      = word_eff ? CW'(32) : CW'(XLEN);
        shamt      = word_eff ? (XLEN - 32) : 0;
        div0       = is_div && (e2 == '0);
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_hit;
    logic [XLEN-1:0] early_val;
    logic [XLEN-1:0] op1_w;
    logic [XLEN-1:0] min_eff;
    logic            ovf;
    logic            mulzero;

    always_comb begin
        op1_w   = word_eff ? ext32(op1[31:0], 1'b1) : op1;
        min_eff = word_eff ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        ovf     = is_div && op2_signed && (e1 == min_eff) && (e2 == '1);
        mulzero = !is_div && ((e1 == '0) || (e2 == '0));
        early_hit = div0 || ovf || mulzero;
        early_val = '0;
        if (div0)
            early_val = op[1] ? op1_w : '1;
        else if (ovf)
            early_val = op[1] ? '0 : op1_w;
    end
`endif

    // One iteration of shift-add multiply and restoring divide
    logic [XLEN:0]     rem_sh;
    logic              ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] mul_acc_d;
    logic [2*XLEN-1:0] div_acc_d;

    always_comb begin
        rem_sh    = {acc_q[2*XLEN-1:XLEN], s_q[XLEN-1]};
        ge        = rem_sh >= {1'b0, d_q};
        rem_sub   = rem_sh[XLEN-1:0] - d_q;
        mul_acc_d = {acc_q[2*XLEN-2:0], 1'b0} + (s_q[XLEN-1] ? {{XLEN{1'b0}}, d_q} : '0);
        div_acc_d = {(ge ? rem_sub : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
    end

    // Sign correction and output selection in FIX
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   result_d;

    always_comb begin
        prod    = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
        if (op_q[1:0] != 2'd0)
            mul_res = word_q ? ext32(prod[63:32], 1'b0) : prod[2*XLEN-1:XLEN];
        else
            mul_res = prod[XLEN-1:0];
        quo = acc_q[XLEN-1:0];
        rem = acc_q[2*XLEN-1:XLEN];
        // A zero divisor yields an all-ones quotient before sign correction; force it afterwards too.
        if (op_q[1])
            div_res = neg1_q ? -rem : rem;
        else if (div0_q)
            div_res = '1;
        else
            div_res = (neg1_q ^ neg2_q) ? -quo : quo;
        raw      = op_q[2] ? div_res : mul_res;
        result_d = word_q ? ext32(raw[31:0], 1'b1) : raw;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            word_q      <= 1'b0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
            div0_q      <= 1'b0;
            cnt_q       <= '0;
            d_q         <= '0;
            s_q         <= '0;
            acc_q       <= '0;
            tag_q       <= '0;
            result_q    <= '0;
            out_tag_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (in_valid) begin
                            op_q    <= op;
                            word_q  <= word_eff;
                            neg1_q  <= neg1;
                            neg2_q  <= neg2;
                            div0_q  <= div0;
                            cnt_q   <= n_eff;
                            d_q     <= is_div ? mag2 : mag1;
                            s_q     <= (is_div ? mag1 : mag2) << shamt;
                            acc_q   <= '0;
                            tag_q   <= tag;
                            state_q <= CALC;
`ifdef MULDIV_EARLY_OUT_EN
                            if (early_hit) begin
                                result_q    <= early_val;
                                out_tag_q   <= tag;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
`endif
                        end
                    end
                    CALC: begin
                        if (cnt_q == '0) begin
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                            s_q   <= {s_q[XLEN-2:0], 1'b0};
                            acc_q <= op_q[2] ? div_acc_d : mul_acc_d;
                        end
                    end
                    FIX: begin
                        result_q    <= result_d;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready  = (state_q == IDLE) && !flush;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;

endmodule
